// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared width helpers and defaults for the FIFO family
package fifo_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;
  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction
  function automatic bit is_pow2(input int d);
    return d > 0 && (d & (d - 1)) == 0;
  endfunction
endpackage

// File: rtl/fifo_ctrl_ram.sv
// RAM_2Port: simple dual-port RAM with one-cycle registered read and read-valid strobe
module RAM_2Port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     i_rst_n,
  input  logic                     i_wr_clk,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic                     i_wr_dv,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_clk,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  input  logic                     i_rd_en,
  output logic                     o_rd_dv,
  output logic [WIDTH-1:0]         o_rd_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge i_wr_clk)
    if (i_wr_dv) mem_q[i_wr_addr] <= i_wr_data;
  // Data port reads unconditionally; only the valid strobe is qualified.
  always_ff @(posedge i_rd_clk)
    o_rd_data <= mem_q[i_rd_addr];
  always_ff @(posedge i_rd_clk or negedge i_rst_n)
    if (!i_rst_n) o_rd_dv <= 1'b0;
    else          o_rd_dv <= i_rd_en;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO controller around RAM_2Port with full/empty/almost flags
// Optional sticky o_overflow/o_underflow ports when FIFO_ERR_FLAGS_EN is defined.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 252,
  parameter int AE_LEVEL = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_dv,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic                   o_full,
  output logic                   o_af_flag,
  input  logic                   i_rd_en,
  output logic                   o_rd_dv,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_empty,
  output logic                   o_ae_flag,
  output logic [cnt_w(DEPTH)-1:0] o_count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                   o_overflow,
  output logic                   o_underflow
`endif
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("fifo_ctrl: DEPTH must be a power of two >= 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_lvl
    $error("fifo_ctrl: AF_LEVEL/AE_LEVEL out of range");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_acc, rd_acc;

  assign o_full    = count_q == FULL_C;
  assign o_empty   = count_q == '0;
  assign o_af_flag = count_q >= AF_C;
  assign o_ae_flag = count_q <= AE_C;
  assign o_count   = count_q;
  assign wr_acc    = i_wr_dv & ~o_full;
  assign rd_acc    = i_rd_en & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (i_wr_dv & o_full);
      unf_q <= unf_q | (i_rd_en & o_empty);
    end
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`endif

  RAM_2Port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .i_rst_n  (i_rst_n),
    .i_wr_clk (i_clk),
    .i_wr_addr(wr_ptr_q),
    .i_wr_dv  (wr_acc),
    .i_wr_data(i_wr_data),
    .i_rd_clk (i_clk),
    .i_rd_addr(rd_ptr_q),
    .i_rd_en  (rd_acc),
    .o_rd_dv  (o_rd_dv),
    .o_rd_data(o_rd_data)
  );
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl at DEPTH=8, AF_LEVEL=6, AE_LEVEL=4
module tb_fifo_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_dv = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, af, rd_dv, empty, ae;
  logic [7:0] rd_data;
  logic [3:0] count;
  int         total = 0, fails = 0;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf, unf;
`endif

  always #5 clk = ~clk;

  fifo_ctrl #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_dv(wr_dv), .i_wr_data(wr_data),
    .o_full(full), .o_af_flag(af), .i_rd_en(rd_en), .o_rd_dv(rd_dv),
    .o_rd_data(rd_data), .o_empty(empty), .o_ae_flag(ae), .o_count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .o_overflow(ovf), .o_underflow(unf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; returns #1 after the edge with strobes dropped.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_dv = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_dv = 1'b0; rd_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    cyc(1'b0, 8'h00, 1'b1);
    chk({tag, "_dv"}, 32'(rd_dv), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(ae), 1);
    chk("rst_af", 32'(af), 0);
    chk("rst_rd_dv", 32'(rd_dv), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: basic write/read ordering
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("t1_count", 32'(count), 4);
    chk("t1_empty", 32'(empty), 0);
    chk("t1_ae", 32'(ae), 1);
    for (int i = 0; i < 4; i++) rd_chk("t1_rd", 8'hA0 + 8'(i));
    chk("t1_empty_end", 32'(empty), 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_dv_drop", 32'(rd_dv), 0);

    // 2: fill, almost-full, full, dropped write, drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      chk("t2_count", 32'(count), 32'(i + 1));
      chk("t2_af", 32'(af), 32'(i + 1 >= 6));
      chk("t2_ae", 32'(ae), 32'(i + 1 <= 4));
    end
    chk("t2_full", 32'(full), 1);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("t2_ovf_count", 32'(count), 8);
    chk("t2_ovf_full", 32'(full), 1);
    for (int i = 0; i < 8; i++) rd_chk("t2_rd", 8'h10 + 8'(i));
    chk("t2_empty", 32'(empty), 1);
    chk("t2_af_end", 32'(af), 0);

    // 3: pointer wrap
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'h30 + 8'(16 * k + i), 1'b0);
      chk("t3_count6", 32'(count), 6);
      for (int i = 0; i < 6; i++) rd_chk("t3_rd", 8'h30 + 8'(16 * k + i));
      chk("t3_count0", 32'(count), 0);
    end

    // 4: simultaneous read+write at mid, full and empty
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0);
    cyc(1'b1, 8'h53, 1'b1);
    chk("t4_mid_count", 32'(count), 3);
    chk("t4_mid_dv", 32'(rd_dv), 1);
    chk("t4_mid_data", 32'(rd_data), 32'h50);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h54 + 8'(i), 1'b0);
    chk("t4_full", 32'(full), 1);
    cyc(1'b1, 8'h99, 1'b1);
    chk("t4_full_count", 32'(count), 7);
    chk("t4_full_data", 32'(rd_data), 32'h51);
    for (int i = 0; i < 7; i++) rd_chk("t4_drain", 8'h52 + 8'(i));
    chk("t4_empty", 32'(empty), 1);
    cyc(1'b1, 8'h77, 1'b1);
    chk("t4_empty_count", 32'(count), 1);
    chk("t4_empty_dv", 32'(rd_dv), 0);
    rd_chk("t4_ft", 8'h77);

    // 5: async reset mid-stream
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t5_pre_count", 32'(count), 5);
    chk("t5_pre_dv", 32'(rd_dv), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_dv", 32'(rd_dv), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1'b1, 8'hC5, 1'b0);
    cyc(1'b1, 8'hC6, 1'b0);
    chk("t5_post_count", 32'(count), 2);
    rd_chk("t5_first", 8'hC5);

`ifdef FIFO_ERR_FLAGS_EN
    // 6: sticky error flags
    rd_chk("t6_drain", 8'hC6);
    chk("t6_unf0", 32'(unf), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_unf", 32'(unf), 1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("t6_unf_sticky", 32'(unf), 1);
    chk("t6_ovf0", 32'(ovf), 0);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("t6_ovf", 32'(ovf), 1);
    for (int i = 0; i < 3; i++) rd_chk("t6_rd", 8'(i));
    chk("t6_ovf_sticky", 32'(ovf), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_ovf_rst", 32'(ovf), 0);
    chk("t6_unf_rst", 32'(unf), 0);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
